// File: rtl/popcount_stream_pkg.sv
// Shared types and helpers for the popcount_stream block.
// Count-width and saturating-add helpers used by the pipeline and its interface.
package popcount_pkg;

  localparam int MAX_CHUNK = 4;

  function automatic int clog2p1(input int w);
    return $clog2(w + 1);
  endfunction

  // Sum of a and b clamped to the largest w-bit value.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [32:0] sum;
    logic [32:0] max;
    sum = {1'b0, a} + {1'b0, b};
    max = (33'd1 << w) - 33'd1;
    return (sum > max) ? max[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/popcount_stream_if.sv
// Word-in / count-out stream bundle for popcount_stream.
// Optional thresh/out_hit signals exist only with POPCOUNT_STREAM_THRESH_EN defined.
interface popcount_stream_if import popcount_pkg::*; #(
  parameter int WIDTH   = 16,
  parameter int TOTAL_W = 16
) ();
  localparam int CW = clog2p1(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [CW-1:0]      out_count;
  logic [TOTAL_W-1:0] out_total;
  logic               out_last;
  logic               out_sat;
`ifdef POPCOUNT_STREAM_THRESH_EN
  logic [CW-1:0]      thresh;
  logic               out_hit;
`endif

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
`ifdef POPCOUNT_STREAM_THRESH_EN
    input  thresh,
    output out_hit,
`endif
    output in_ready, out_valid, out_count, out_total, out_last, out_sat
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
`ifdef POPCOUNT_STREAM_THRESH_EN
    output thresh,
    input  out_hit,
`endif
    input  in_ready, out_valid, out_count, out_total, out_last, out_sat
  );

endinterface

// File: rtl/popcount_stream_chunk.sv
// popcount_chunk: combinational set-bit count of one CHUNK-bit slice.
module popcount_chunk import popcount_pkg::*; #(
  parameter  int CHUNK = 4,
  localparam int CNT_W = clog2p1(CHUNK)
) (
  input  logic [CHUNK-1:0] bits,
  output logic [CNT_W-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < CHUNK; i++) begin
      cnt = cnt + CNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/popcount_stream.sv
// popcount_stream: two-stage pipelined popcount with per-packet saturating total.
// Define POPCOUNT_STREAM_THRESH_EN to add the per-word thresh compare (out_hit).
module popcount_stream import popcount_pkg::*; #(
  parameter int WIDTH   = 16,
  parameter int CHUNK   = 4,
  parameter int TOTAL_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  popcount_stream_if.slave bus
);

  localparam int CW  = clog2p1(WIDTH);
  localparam int NCH = WIDTH / CHUNK;
  localparam int SCW = clog2p1(CHUNK);
  localparam logic [TOTAL_W-1:0] TOTAL_MAX = '1;

  logic adv;
  logic [NCH-1:0][SCW-1:0] chunk_cnt;

  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_last_q,  s1_last_d;
  logic [NCH-1:0][SCW-1:0] s1_cnt_q,   s1_cnt_d;

  logic               out_valid_q, out_valid_d;
  logic [CW-1:0]      out_count_q, out_count_d;
  logic [TOTAL_W-1:0] out_total_q, out_total_d;
  logic               out_last_q,  out_last_d;
  logic               out_sat_q,   out_sat_d;
  logic [TOTAL_W-1:0] acc_q,       acc_d;
  logic               sticky_q,    sticky_d;

  logic [CW-1:0] word_sum;
  logic          ovf;

`ifdef POPCOUNT_STREAM_THRESH_EN
  logic [CW-1:0] s1_thresh_q, s1_thresh_d;
  logic          out_hit_q,   out_hit_d;
`endif

  // One enable for both stages: the whole pipe moves or the whole pipe holds.
  assign adv          = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = rst_n & adv;

  for (genvar g = 0; g < NCH; g++) begin : g_chunk
    popcount_chunk #(.CHUNK(CHUNK)) u_chunk (
      .bits (bus.in_data[g*CHUNK +: CHUNK]),
      .cnt  (chunk_cnt[g])
    );
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    s1_cnt_d   = s1_cnt_q;
`ifdef POPCOUNT_STREAM_THRESH_EN
    s1_thresh_d = s1_thresh_q;
`endif
    if (adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_last_d = bus.in_last;
        s1_cnt_d  = chunk_cnt;
`ifdef POPCOUNT_STREAM_THRESH_EN
        s1_thresh_d = bus.thresh;
`endif
      end
    end
  end

  always_comb begin
    word_sum = '0;
    for (int i = 0; i < NCH; i++) begin
      word_sum = word_sum + CW'(s1_cnt_q[i]);
    end

    // The word leaving S2 on this edge folds into acc before the next word's total is formed.
    acc_d    = acc_q;
    sticky_d = sticky_q;
    if (out_valid_q && bus.out_ready) begin
      if (out_last_q) begin
        acc_d    = '0;
        sticky_d = 1'b0;
      end else begin
        acc_d    = out_total_q;
        sticky_d = out_sat_q;
      end
    end

    ovf = ({1'b0, acc_d} + (TOTAL_W+1)'(word_sum)) > {1'b0, TOTAL_MAX};

    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    out_total_d = out_total_q;
    out_last_d  = out_last_q;
    out_sat_d   = out_sat_q;
`ifdef POPCOUNT_STREAM_THRESH_EN
    out_hit_d = out_hit_q;
`endif
    if (adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_count_d = word_sum;
        out_total_d = TOTAL_W'(sat_add(32'(acc_d), 32'(word_sum), TOTAL_W));
        out_last_d  = s1_last_q;
        out_sat_d   = sticky_d | ovf;
`ifdef POPCOUNT_STREAM_THRESH_EN
        out_hit_d = (word_sum >= s1_thresh_q);
`endif
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_total_q <= '0;
      out_last_q  <= 1'b0;
      out_sat_q   <= 1'b0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
`ifdef POPCOUNT_STREAM_THRESH_EN
      s1_thresh_q <= '0;
      out_hit_q   <= 1'b0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_cnt_q    <= s1_cnt_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_total_q <= out_total_d;
      out_last_q  <= out_last_d;
      out_sat_q   <= out_sat_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
`ifdef POPCOUNT_STREAM_THRESH_EN
      s1_thresh_q <= s1_thresh_d;
      out_hit_q   <= out_hit_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_count = out_count_q;
  assign bus.out_total = out_total_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sat   = out_sat_q;
`ifdef POPCOUNT_STREAM_THRESH_EN
  assign bus.out_hit   = out_hit_q;
`endif

endmodule
